// File: rtl/pipe_pkg.sv
// Shared PIPE definitions: opcode map, instruction classifiers and MEM FSM states.
package pipe_pkg;

  localparam int DATA_W = 32;

  localparam logic [5:0] OP_NOP  = 6'b000000;
  localparam logic [5:0] OP_ADD  = 6'b000001;
  localparam logic [5:0] OP_SUB  = 6'b000010;
  localparam logic [5:0] OP_AND  = 6'b000011;
  localparam logic [5:0] OP_OR   = 6'b000100;
  localparam logic [5:0] OP_SLT  = 6'b000101;
  localparam logic [5:0] OP_XOR  = 6'b000110;
  localparam logic [5:0] OP_LW   = 6'b001000;
  localparam logic [5:0] OP_SW   = 6'b001001;
  localparam logic [5:0] OP_BEQZ = 6'b001010;
  localparam logic [5:0] OP_JMP  = 6'b001011;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } mem_state_t;

  function automatic logic is_load(input logic [31:0] ir);
    return ir[31:26] == OP_LW;
  endfunction

  function automatic logic is_store(input logic [31:0] ir);
    return ir[31:26] == OP_SW;
  endfunction

endpackage

// File: rtl/mem_access_data_mem.sv
// Data memory: combinational read, write on the rising clock edge, no reset.
module data_mem #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  // Store commits only when the MEM stage asserts its completion write enable
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/mem_access.sv
// PIPE MEM stage: performs LW/SW against data_mem with MEM_LAT-cycle accesses,
// stalls upstream while an access is in flight, and registers the MEM/WB latch.
module mem_access
  import pipe_pkg::*;
#(
  parameter int DATA_W  = pipe_pkg::DATA_W,
  parameter int ADDR_W  = 10,
  parameter int MEM_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [31:0]       EX_MEM_IR,
  input  logic [DATA_W-1:0] EX_MEM_ALU_output,
  input  logic [DATA_W-1:0] EX_MEM_B,
  input  logic              EX_MEM_valid,
  output logic              mem_stall,
  output logic [31:0]       MEM_WB_IR,
  output logic [DATA_W-1:0] MEM_WB_ALU_output,
  output logic [DATA_W-1:0] MEM_WB_LMD,
  output logic              MEM_WB_valid
);

  localparam int CNT_W = $clog2(MEM_LAT) + 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(MEM_LAT - 1);

  mem_state_t        state, state_nxt;
  logic [CNT_W-1:0]  cnt;
  logic              ld_op, st_op, mem_op;
  logic              done;
  logic              mem_we;
  logic [ADDR_W-1:0] word_idx;
  logic [DATA_W-1:0] rdata;

  assign ld_op    = EX_MEM_valid && is_load(EX_MEM_IR);
  assign st_op    = EX_MEM_valid && is_store(EX_MEM_IR);
  assign mem_op   = ld_op || st_op;
  assign word_idx = EX_MEM_ALU_output[ADDR_W+1:2];

  data_mem #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_data_mem (
    .clk   (clk),
    .we    (mem_we),
    .addr  (word_idx),
    .wdata (EX_MEM_B),
    .rdata (rdata)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Next state: leave IDLE only for multi-cycle accesses, return on the last cycle
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (mem_op && MEM_LAT > 1) state_nxt = ST_WAIT;
      ST_WAIT: if (cnt == LAST)           state_nxt = ST_IDLE;
      default:                            state_nxt = ST_IDLE;
    endcase
  end

  // Outputs: completion strobe, stall and store enable; all quiet while in reset
  always_comb begin
    done      = 1'b0;
    mem_stall = 1'b0;
    case (state)
      ST_IDLE: begin
        done      = !mem_op || (MEM_LAT == 1);
        mem_stall = mem_op && (MEM_LAT > 1);
      end
      ST_WAIT: begin
        done      = (cnt == LAST);
        mem_stall = (cnt < LAST);
      end
      default: ;
    endcase
    mem_stall = mem_stall && rst_n;
    mem_we    = st_op && done && rst_n;
  end

  // Access cycle counter: 1 on entry to WAIT, cleared when the access completes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (state == ST_IDLE) begin
      cnt <= (mem_op && MEM_LAT > 1) ? CNT_W'(1) : '0;
    end else if (cnt < LAST) begin
      cnt <= cnt + CNT_W'(1);
    end else begin
      cnt <= '0;
    end
  end

  // MEM/WB latch: load on completion, insert a bubble on every stalled edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      MEM_WB_IR         <= '0;
      MEM_WB_ALU_output <= '0;
      MEM_WB_LMD        <= '0;
      MEM_WB_valid      <= 1'b0;
    end else if (done) begin
      MEM_WB_IR         <= EX_MEM_IR;
      MEM_WB_ALU_output <= EX_MEM_ALU_output;
      MEM_WB_valid      <= EX_MEM_valid;
      if (ld_op) MEM_WB_LMD <= rdata;
    end else begin
      MEM_WB_valid      <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mem_access.sv
// Directed bench for mem_access: three instances (1-cycle, 3-cycle, 4-bit address).
module tb_mem_access;

  localparam logic [31:0] IR_ADD = 32'h04221800;
  localparam logic [31:0] IR_SW  = 32'h24850008;
  localparam logic [31:0] IR_LW  = 32'h20850004;
  localparam logic [31:0] IR_UNK = 32'hFC000000;

  logic        clk = 1'b0;
  logic        rst_n [3];
  logic [31:0] ir    [3];
  logic [31:0] alu   [3];
  logic [31:0] b     [3];
  logic        v     [3];
  logic        stall [3];
  logic [31:0] wir   [3];
  logic [31:0] walu  [3];
  logic [31:0] lmd   [3];
  logic        wv    [3];

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mem_access #(.DATA_W(32), .ADDR_W(10), .MEM_LAT(1)) u_l1 (
    .clk(clk), .rst_n(rst_n[0]), .EX_MEM_IR(ir[0]), .EX_MEM_ALU_output(alu[0]),
    .EX_MEM_B(b[0]), .EX_MEM_valid(v[0]), .mem_stall(stall[0]), .MEM_WB_IR(wir[0]),
    .MEM_WB_ALU_output(walu[0]), .MEM_WB_LMD(lmd[0]), .MEM_WB_valid(wv[0]));

  mem_access #(.DATA_W(32), .ADDR_W(10), .MEM_LAT(3)) u_l3 (
    .clk(clk), .rst_n(rst_n[1]), .EX_MEM_IR(ir[1]), .EX_MEM_ALU_output(alu[1]),
    .EX_MEM_B(b[1]), .EX_MEM_valid(v[1]), .mem_stall(stall[1]), .MEM_WB_IR(wir[1]),
    .MEM_WB_ALU_output(walu[1]), .MEM_WB_LMD(lmd[1]), .MEM_WB_valid(wv[1]));

  mem_access #(.DATA_W(32), .ADDR_W(4), .MEM_LAT(1)) u_w4 (
    .clk(clk), .rst_n(rst_n[2]), .EX_MEM_IR(ir[2]), .EX_MEM_ALU_output(alu[2]),
    .EX_MEM_B(b[2]), .EX_MEM_valid(v[2]), .mem_stall(stall[2]), .MEM_WB_IR(wir[2]),
    .MEM_WB_ALU_output(walu[2]), .MEM_WB_LMD(lmd[2]), .MEM_WB_valid(wv[2]));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Upstream must hold EX_MEM_* stable across any edge where mem_stall was high
  logic        arm = 1'b0;
  logic [96:0] held = '0;
  always @(posedge clk) begin
    if (arm && rst_n[1] && ({ir[1], alu[1], b[1], v[1]} !== held)) begin
      n_err++;
      $display("FAIL stable_inputs: got %h expected %h", {ir[1], alu[1], b[1], v[1]}, held);
    end
    arm  = stall[1] && rst_n[1];
    held = {ir[1], alu[1], b[1], v[1]};
  end

  typedef struct {
    int          dut;
    logic [31:0] ir, alu, b;
    logic        v;
    logic [31:0] e_ir, e_alu, e_lmd;
    logic        e_v;
  } vec_t;

  vec_t tv [12];

  // Multi-cycle access on the MEM_LAT=3 instance: stall for 2 cycles, bubble on 2 edges
  task automatic mc(input string nm, input logic [31:0] i_ir, input logic [31:0] i_alu,
                    input logic [31:0] i_b, input logic chk_lmd, input logic [31:0] e_lmd);
    @(negedge clk);
    ir[1] = i_ir; alu[1] = i_alu; b[1] = i_b; v[1] = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk($sformatf("%s_stall%0d", nm, k), {31'd0, stall[1]}, (k < 2) ? 32'd1 : 32'd0);
      @(posedge clk); #1;
      chk($sformatf("%s_valid%0d", nm, k), {31'd0, wv[1]}, (k == 2) ? 32'd1 : 32'd0);
      if (k < 2) @(negedge clk);
    end
    chk({nm, "_ir"}, wir[1], i_ir);
    chk({nm, "_alu"}, walu[1], i_alu);
    if (chk_lmd) chk({nm, "_lmd"}, lmd[1], e_lmd);
  endtask

  initial begin
    for (int d = 0; d < 3; d++) begin
      rst_n[d] = 1'b0; ir[d] = '0; alu[d] = '0; b[d] = '0; v[d] = 1'b0;
    end
    // Reset with a load presented: no stall, all MEM/WB outputs zero
    ir[1] = IR_LW; alu[1] = 32'd8; v[1] = 1'b1;
    ir[0] = IR_ADD; alu[0] = 32'd9; v[0] = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_stall", {31'd0, stall[1]}, 32'd0);
    chk("rst_ir", wir[1], 32'd0);
    chk("rst_alu", walu[1], 32'd0);
    chk("rst_lmd", lmd[1], 32'd0);
    chk("rst_valid", {31'd0, wv[1]}, 32'd0);
    chk("rst_ir0", wir[0], 32'd0);
    chk("rst_valid0", {31'd0, wv[0]}, 32'd0);
    @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      ir[d] = '0; alu[d] = '0; b[d] = '0; v[d] = 1'b0; rst_n[d] = 1'b1;
    end

    tv[0]  = '{0, 32'd0,   32'd0,   32'd0,   1, 32'd0,   32'd0,   32'd0,   1};
    tv[1]  = '{0, IR_ADD,  32'd456, 32'd0,   1, IR_ADD,  32'd456, 32'd0,   1};
    tv[2]  = '{0, IR_SW,   32'd8,   32'd123, 1, IR_SW,   32'd8,   32'd0,   1};
    tv[3]  = '{0, IR_LW,   32'd8,   32'd0,   1, IR_LW,   32'd8,   32'd123, 1};
    tv[4]  = '{0, IR_ADD,  32'd7,   32'd0,   1, IR_ADD,  32'd7,   32'd123, 1};
    tv[5]  = '{0, IR_LW,   32'd16,  32'd0,   0, IR_LW,   32'd16,  32'd123, 0};
    tv[6]  = '{0, IR_UNK,  32'd5,   32'd0,   1, IR_UNK,  32'd5,   32'd123, 1};
    tv[7]  = '{0, IR_SW,   32'd16,  32'hDEADBEEF, 1, IR_SW, 32'd16, 32'd123, 1};
    tv[8]  = '{0, IR_LW,   32'd16,  32'd0,   1, IR_LW,   32'd16,  32'hDEADBEEF, 1};
    tv[9]  = '{0, IR_LW,   32'd8,   32'd0,   1, IR_LW,   32'd8,   32'd123, 1};
    tv[10] = '{2, IR_SW,   32'd4,   32'd77,  1, IR_SW,   32'd4,   32'd0,   1};
    tv[11] = '{2, IR_LW,   32'd71,  32'd0,   1, IR_LW,   32'd71,  32'd77,  1};

    for (int i = 0; i < 12; i++) begin
      int d;
      d = tv[i].dut;
      ir[d] = tv[i].ir; alu[d] = tv[i].alu; b[d] = tv[i].b; v[d] = tv[i].v;
      #1;
      chk($sformatf("v%0d_stall", i), {31'd0, stall[d]}, 32'd0);
      @(posedge clk); #1;
      chk($sformatf("v%0d_ir", i), wir[d], tv[i].e_ir);
      chk($sformatf("v%0d_alu", i), walu[d], tv[i].e_alu);
      chk($sformatf("v%0d_lmd", i), lmd[d], tv[i].e_lmd);
      chk($sformatf("v%0d_valid", i), {31'd0, wv[d]}, {31'd0, tv[i].e_v});
      @(negedge clk);
    end
    v[0] = 1'b0; v[2] = 1'b0;

    // Multi-cycle store then load on the MEM_LAT=3 instance
    mc("mc_sw8", IR_SW, 32'd8, 32'd123, 1'b0, 32'd0);
    mc("mc_lw8", IR_LW, 32'd8, 32'd0, 1'b1, 32'd123);
    mc("mc_sw12", IR_SW, 32'd12, 32'd55, 1'b0, 32'd0);

    // Store of 99 aborted by reset while in WAIT
    @(negedge clk);
    ir[1] = IR_SW; alu[1] = 32'd12; b[1] = 32'd99; v[1] = 1'b1;
    #1 chk("ab_stall", {31'd0, stall[1]}, 32'd1);
    @(negedge clk);
    rst_n[1] = 1'b0;
    ir[1] = '0; alu[1] = '0; b[1] = '0; v[1] = 1'b0;
    #1;
    chk("ab_rst_stall", {31'd0, stall[1]}, 32'd0);
    chk("ab_rst_lmd", lmd[1], 32'd0);
    chk("ab_rst_ir", wir[1], 32'd0);
    @(negedge clk);
    rst_n[1] = 1'b1;
    mc("mc_lw12", IR_LW, 32'd12, 32'd0, 1'b1, 32'd55);
    @(negedge clk);
    v[1] = 1'b0;
    @(posedge clk); #1;
    chk("idle_valid", {31'd0, wv[1]}, 32'd0);
    chk("idle_lmd", lmd[1], 32'd55);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
